vga_output_driver: RTL and testbench

- Transmit-side counterpart of the pin-sampling input buffer: generates VGA raster timing, issues framebuffer read requests, and drives registered, latency-aligned RGB/HSYNC/VSYNC to the output pins.
- Sits between the framebuffer read port and the VGA connector.
- All pin outputs come straight from flops, with no combinational path to pins.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_output_driver.sv | 129 ++++++++++++
 tb/tb_vga_output_driver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : default 640x480@60 raster timing and total-size helper
// Revision       : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// vga_delay_line : enable-gated, resettable shift register of DEPTH stages
// Revision       : 1.0
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_output_driver.sv
// ============================================================================
// vga_output_driver : VGA raster timing, framebuffer read requests and
//                     registered, latency-aligned RGB/HSYNC/VSYNC pin drive
// Revision          : 1.0
// ============================================================================
`default_nettype none

module vga_output_driver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = DEF_SYNC_POL,
  parameter int PIX_WIDTH  = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_en,
  output logic                        rd_en,
  output logic [$clog2(H_ACTIVE)-1:0] rd_x,
  output logic [$clog2(V_ACTIVE)-1:0] rd_y,
  input  logic [PIX_WIDTH-1:0]        pixel_in,
  output logic [PIX_WIDTH-1:0]        vga_rgb,
  output logic                        vga_hsync,
  output logic                        vga_vsync,
  output logic                        frame_start
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          visible;
  logic          hs_now;
  logic          vs_now;
  logic          hs_raw;
  logic          vs_raw;
  logic          active_d;
  logic          hs_d;
  logic          vs_d;

  assign visible = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign hs_now  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_now  = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Line and frame wrap share a tick so the raster has no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en  <= 1'b0;
      rd_x   <= '0;
      rd_y   <= '0;
      hs_raw <= 1'b0;
      vs_raw <= 1'b0;
    end else if (pix_en) begin
      rd_en  <= visible;
      rd_x   <= visible ? h_cnt[XW-1:0] : '0;
      rd_y   <= visible ? v_cnt[YW-1:0] : '0;
      hs_raw <= hs_now;
      vs_raw <= vs_now;
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (RD_LATENCY)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   ({rd_en, hs_raw, vs_raw}),
    .dout  ({active_d, hs_d, vs_d})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb   <= '0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
    end else if (pix_en) begin
      vga_rgb   <= active_d ? pixel_in : '0;
      vga_hsync <= hs_d ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= vs_d ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Evaluated every clk so the pulse is one clk wide regardless of pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_output_driver.sv
// ============================================================================
// tb_vga_output_driver : randomized check of vga_output_driver against a
//                        tick-indexed raster model on a reduced timing
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_vga_output_driver;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam int PW = 3;
  localparam int XW = $clog2(HA);
  localparam int YW = $clog2(VA);
  localparam bit POL = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [PW-1:0] pixel_in = '0;
  logic [PW-1:0] vga_rgb;
  logic          vga_hsync;
  logic          vga_vsync;
  logic          frame_start;

  vga_output_driver #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .PIX_WIDTH (PW), .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .pixel_in    (pixel_in),
    .vga_rgb     (vga_rgb),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;          // pixel ticks since reset release
  bit all_ones = 1'b0;
  logic [PW-1:0] mem [VA][HA];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, n);
    end
  endtask

  // Position p is the p-th pixel of the raster since reset (0-based).
  function automatic int pos_h(input int p); return p % HT; endfunction
  function automatic int pos_v(input int p); return (p / HT) % VT; endfunction
  function automatic bit pos_vis(input int p);
    return (pos_h(p) < HA) && (pos_v(p) < VA);
  endfunction
  function automatic logic [PW-1:0] pix_of(input int p);
    return all_ones ? '1 : mem[pos_v(p)][pos_h(p)];
  endfunction

  task automatic check_all(input bit fs_exp);
    int p, r, eh, ev;
    logic [PW-1:0] ergb;
    logic ehs, evs;
    p = n - 1;
    if (n >= 1 && pos_vis(p)) begin
      check_val("rd_en", rd_en, 1);
      check_val("rd_xy", {rd_x, rd_y}, (pos_h(p) << YW) | pos_v(p));
    end else begin
      check_val("rd_en", rd_en, 0);
      check_val("rd_xy", {rd_x, rd_y}, 0);
    end
    r = n - LAT - 2;
    ergb = '0;
    ehs = ~POL;
    evs = ~POL;
    if (r >= 0) begin
      eh = pos_h(r);
      ev = pos_v(r);
      if (pos_vis(r)) ergb = pix_of(r);
      if (eh >= HA + HF && eh < HA + HF + HS) ehs = POL;
      if (ev >= VA + VF && ev < VA + VF + VS) evs = POL;
    end
    check_val("rgb", vga_rgb, ergb);
    check_val("hsync", vga_hsync, ehs);
    check_val("vsync", vga_vsync, evs);
    check_val("frame_start", frame_start, fs_exp);
  endtask

  // Framebuffer answers each request LAT ticks later; blank slots get garbage.
  task automatic drive_pixel();
    int q;
    q = n - LAT - 1;
    if (all_ones)                 pixel_in = '1;
    else if (q >= 0 && pos_vis(q)) pixel_in = pix_of(q);
    else                          pixel_in = PW'($urandom);
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    if (en) n++;
    #1;
    check_all(en && ((n - 1) % FT == 0));
    if (en) drive_pixel();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all(1'b0);
    drive_pixel();
    @(posedge clk);
    #1;
    check_all(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        mem[y][x] = PW'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0);
    rst_n = 1'b1;

    // Continuous pixel clock over two frames and a bit.
    for (int i = 0; i < 2 * FT + 20; i++) step(1'b1);

    // Run to mid-frame, then reset asynchronously.
    for (int i = 0; i < 2 * FT && ((n - 1) % FT) != 3 * HT + 4; i++) step(1'b1);
    check_val("mid_pos", (n - 1) % FT, 3 * HT + 4);
    do_reset();

    // Alternating pixel enable.
    for (int i = 0; i < 4 * FT; i++) step(i[0] == 1'b0);

    // Saturated input data with random pixel enable.
    all_ones = 1'b1;
    do_reset();
    for (int i = 0; i < 3 * FT; i++) step(($urandom % 4) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
